// File: rtl/ahb_slave_mem_if.sv
// AHB5 subordinate-side bus bundle for ahb_slave_mem.
// Signals: hsel, haddr, htrans, hwrite, hsize, hburst, hexcl, hwdata and hready
// are driven by the manager side. hrdata, hreadyout, hresp and hexokay are the
// subordinate response.
interface ahb_slave_mem_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic                  hexcl;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic                  hexokay;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hexcl, hwdata, hready,
    output hrdata, hreadyout, hresp, hexokay
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hexcl, hwdata,
    input  hready, hrdata, hreadyout, hresp, hexokay
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB5 subordinate memory model with programmable wait states, byte-lane
// writes, a two-cycle ERROR response and a single-entry exclusive monitor.
// Ports: hclk (clock), hrst (synchronous active-high reset), bus (slave modport
// of ahb_slave_mem_if carrying the address/data phase and the response).
module ahb_slave_mem #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] ERR_BASE    = ADDR_WIDTH'(32'h8000_0000)
) (
  input logic            hclk,
  input logic            hrst,
  ahb_slave_mem_if.slave bus
);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned BYTE_W = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * NBYTES);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t              state;
  logic [3:0]          count;
  logic                p_valid, p_write, p_excl, p_exok;
  logic [IDX_W-1:0]    p_idx;
  logic [NBYTES-1:0]   p_strb;
  logic                resv_valid;
  logic [IDX_W-1:0]    resv_idx;
  logic                ready_q, exokay_q;
  logic [1:0]          resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                accept_c, req_err_c, misalign_c;
  logic [BYTE_W-1:0]   req_off_c;
  logic [IDX_W-1:0]    req_idx_c;
  logic [NBYTES-1:0]   req_strb_c;
  logic                commit_c, entry_c, e_write_c, e_excl_c;
  logic [IDX_W-1:0]    e_idx_c;
  logic                resv_clear_c, resv_hit_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic                unused_c;

  assign bus.hreadyout = ready_q;
  assign bus.hresp     = resp_q;
  assign bus.hrdata    = rdata_q;
  assign bus.hexokay   = exokay_q;

  // hburst is informational and htrans[0] only separates IDLE from BUSY
  assign unused_c = ^{bus.hburst, bus.htrans[0]};

  // Address-phase decode
  assign accept_c  = bus.hsel && bus.hready && bus.htrans[1] &&
                     (state == S_IDLE || state == S_ERR2);
  assign req_off_c = bus.haddr[BYTE_W-1:0];
  assign req_idx_c = bus.haddr[BYTE_W +: IDX_W];

  always_comb begin
    misalign_c = 1'b0;
    case (bus.hsize)
      3'd0:    misalign_c = 1'b0;
      3'd1:    misalign_c = bus.haddr[0];
      3'd2:    misalign_c = |bus.haddr[1:0];
      3'd3:    misalign_c = |bus.haddr[2:0];
      default: misalign_c = 1'b1;
    endcase
  end

  assign req_err_c = (bus.haddr >= ERR_BASE) ||
                     ({1'b0, bus.haddr} >= MEM_BYTES) ||
                     misalign_c ||
                     (bus.hsize > 3'(BYTE_W));

  // Little-endian lane strobes for the requested size and offset
  always_comb begin
    req_strb_c = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (i >= int'(req_off_c) && i < int'(req_off_c) + (1 << int'(bus.hsize)))
        req_strb_c[i] = 1'b1;
    end
  end

  // A write commits at the end of its completion cycle; failed exclusives never do
  assign commit_c = (state == S_IDLE) && p_valid && p_write && (!p_excl || p_exok);

  // Completion entry: the edge that makes the next cycle the completion cycle
  assign entry_c   = (accept_c && !req_err_c && WS == 4'd0) ||
                     (state == S_WAIT && count == 4'd1);
  assign e_write_c = (state == S_WAIT) ? p_write : bus.hwrite;
  assign e_excl_c  = (state == S_WAIT) ? p_excl  : bus.hexcl;
  assign e_idx_c   = (state == S_WAIT) ? p_idx   : req_idx_c;

  // A write landing on the reserved word (normal or exclusive) kills the reservation
  assign resv_clear_c = commit_c && resv_valid && (p_idx == resv_idx);
  assign resv_hit_c   = resv_valid && (resv_idx == e_idx_c) && !resv_clear_c;

  // Read data with forwarding from a write committing on the same edge
  always_comb begin
    rd_word_c = mem[e_idx_c];
    if (commit_c && p_idx == e_idx_c) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (p_strb[i]) rd_word_c[8*i +: 8] = bus.hwdata[8*i +: 8];
      end
    end
  end

  // Memory array; not reset
  always_ff @(posedge hclk) begin
    if (commit_c && !hrst) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (p_strb[i]) mem[p_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  // Response FSM, pending transfer and exclusive reservation
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state      <= S_IDLE;
      count      <= 4'd0;
      p_valid    <= 1'b0;
      p_write    <= 1'b0;
      p_excl     <= 1'b0;
      p_exok     <= 1'b0;
      p_idx      <= '0;
      p_strb     <= '0;
      resv_valid <= 1'b0;
      resv_idx   <= '0;
      ready_q    <= 1'b1;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
      exokay_q   <= 1'b0;
    end else begin
      rdata_q  <= '0;
      exokay_q <= 1'b0;
      if (resv_clear_c) resv_valid <= 1'b0;

      unique case (state)
        S_IDLE, S_ERR2: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= RESP_OKAY;
          p_valid <= 1'b0;
          if (accept_c) begin
            if (req_err_c) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= RESP_ERROR;
            end else begin
              p_valid <= 1'b1;
              p_write <= bus.hwrite;
              p_excl  <= bus.hexcl;
              p_idx   <= req_idx_c;
              p_strb  <= req_strb_c;
              if (WS != 4'd0) begin
                state   <= S_WAIT;
                count   <= WS;
                ready_q <= 1'b0;
              end
            end
          end
        end
        S_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= RESP_ERROR;
        end
        default: state <= S_IDLE;
      endcase

      if (entry_c) begin
        rdata_q  <= e_write_c ? '0 : rd_word_c;
        exokay_q <= e_excl_c && (!e_write_c || resv_hit_c);
        p_exok   <= resv_hit_c;
        if (e_excl_c && !e_write_c) begin
          resv_valid <= 1'b1;
          resv_idx   <= e_idx_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a zero-wait instance and a three-wait
// instance share one stimulus bus; a scoreboard of expected data-phase
// responses is filled as addresses are driven and drained by a monitor.
module tb_ahb_slave_mem;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_D = 3'd3;

  typedef struct {
    int          tag;
    int          waits;
    logic [1:0]  resp;
    logic        chk;
    logic [31:0] rdata;
    logic        exok;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hrst = 1'b1;
  logic        sel = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = SZ_W;
  logic [2:0]  hburst = 3'd0;
  logic        hexcl = 1'b0;
  logic [31:0] hwdata = '0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cur_ws = 0;
  logic mon_en = 1'b0;
  exp_t q[$];

  ahb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
  ahb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();

  assign ifa.hsel = hsel & ~sel;   assign ifb.hsel = hsel & sel;
  assign ifa.haddr = haddr;        assign ifb.haddr = haddr;
  assign ifa.htrans = htrans;      assign ifb.htrans = htrans;
  assign ifa.hwrite = hwrite;      assign ifb.hwrite = hwrite;
  assign ifa.hsize = hsize;        assign ifb.hsize = hsize;
  assign ifa.hburst = hburst;      assign ifb.hburst = hburst;
  assign ifa.hexcl = hexcl;        assign ifb.hexcl = hexcl;
  assign ifa.hwdata = hwdata;      assign ifb.hwdata = hwdata;
  assign ifa.hready = ifa.hreadyout;
  assign ifb.hready = ifb.hreadyout;

  logic        ready, exok;
  logic [1:0]  resp;
  logic [31:0] rdata;
  assign ready = sel ? ifb.hreadyout : ifa.hreadyout;
  assign resp  = sel ? ifb.hresp     : ifa.hresp;
  assign rdata = sel ? ifb.hrdata    : ifa.hrdata;
  assign exok  = sel ? ifb.hexokay   : ifa.hexokay;

  ahb_slave_mem #(.WAIT_STATES(0)) dut_a (.hclk(hclk), .hrst(hrst), .bus(ifa.slave));
  ahb_slave_mem #(.WAIT_STATES(3)) dut_b (.hclk(hclk), .hrst(hrst), .bus(ifb.slave));

  always #5 hclk = ~hclk;

  initial forever begin
    @(posedge hclk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  // Monitor: counts wait cycles of the current data phase and pops on completion
  initial begin
    exp_t e;
    logic dp_active;
    int   waits_seen;
    dp_active  = 1'b0;
    waits_seen = 0;
    forever begin
      @(negedge hclk);
      if (hrst || !mon_en) begin
        dp_active  = 1'b0;
        waits_seen = 0;
      end else begin
        if (dp_active) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed data phase expected none");
          end else if (!ready) begin
            waits_seen++;
            chk($sformatf("t%0d_wait_rdata", q[0].tag), rdata, 32'h0);
            chk($sformatf("t%0d_wait_resp", q[0].tag), 32'(resp), 32'(q[0].resp));
          end else begin
            e = q.pop_front();
            chk($sformatf("t%0d_waits", e.tag), 32'(waits_seen), 32'(e.waits));
            chk($sformatf("t%0d_resp", e.tag), 32'(resp), 32'(e.resp));
            chk($sformatf("t%0d_exokay", e.tag), 32'(exok), 32'(e.exok));
            if (e.chk) chk($sformatf("t%0d_rdata", e.tag), rdata, e.rdata);
            waits_seen = 0;
          end
        end
        if (ready) dp_active = hsel && htrans[1];
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Wait for the current cycle to be ready, then cross the accepting edge
  task automatic go();
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $error("FAIL go_timeout: observed hreadyout=0 expected 1 within 40 cycles");
    end
    tick();
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [1:0] tr, input logic x);
    hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr; hexcl = x;
  endtask

  task automatic push(input int tag, input int wt, input logic [1:0] rs,
                      input logic ck, input logic [31:0] rd, input logic ex);
    exp_t e;
    e.tag = tag; e.waits = wt; e.resp = rs; e.chk = ck; e.rdata = rd; e.exok = ex;
    q.push_back(e);
  endtask

  task automatic wr(input int tag, input logic [31:0] a, input logic [2:0] sz,
                    input logic [1:0] tr, input logic x, input logic ex);
    drive(a, 1'b1, sz, tr, x);
    push(tag, cur_ws, 2'b00, 1'b0, 32'h0, ex);
  endtask

  task automatic rd(input int tag, input logic [31:0] a, input logic [2:0] sz,
                    input logic [1:0] tr, input logic x, input logic [31:0] d, input logic ex);
    drive(a, 1'b0, sz, tr, x);
    push(tag, cur_ws, 2'b00, 1'b1, d, ex);
  endtask

  task automatic err(input int tag, input logic [31:0] a, input logic [2:0] sz);
    drive(a, 1'b0, sz, NONSEQ, 1'b0);
    push(tag, 1, 2'b01, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = IDLE; hexcl = 1'b0; hburst = 3'd0;
  endtask

  initial begin
    int c0;
    repeat (3) tick();
    hrst = 1'b0;
    tick();
    chk("rst_a_ready", 32'(ifa.hreadyout), 32'h1);
    chk("rst_a_resp",  32'(ifa.hresp),     32'h0);
    chk("rst_a_rdata", ifa.hrdata,         32'h0);
    chk("rst_a_exok",  32'(ifa.hexokay),   32'h0);
    chk("rst_b_ready", 32'(ifb.hreadyout), 32'h1);
    chk("rst_b_resp",  32'(ifb.hresp),     32'h0);
    mon_en = 1'b1;

    // T1: zero-wait write then read with forwarding
    wr(11, 32'h10, SZ_W, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'hDEAD_BEEF;
    rd(12, 32'h10, SZ_W, NONSEQ, 1'b0, 32'hDEAD_BEEF, 1'b0); go();
    idle(); go();

    // T3: byte and halfword lanes
    wr(31, 32'h10, SZ_W, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'h1122_3344;
    wr(32, 32'h13, SZ_B, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'hAA00_0000;
    wr(33, 32'h14, SZ_W, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'h1234_5678;
    wr(34, 32'h16, SZ_H, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'hBEEF_0000;
    rd(35, 32'h10, SZ_W, NONSEQ, 1'b0, 32'hAA22_3344, 1'b0); go();
    rd(36, 32'h14, SZ_W, NONSEQ, 1'b0, 32'hBEEF_5678, 1'b0); go();
    idle(); go();

    // T4: error window, follow-on accept in ERR2, misalignment, top word, size
    err(41, 32'h8000_0000, SZ_W); go();
    rd(42, 32'h10, SZ_W, NONSEQ, 1'b0, 32'hAA22_3344, 1'b0); go();
    err(43, 32'h1, SZ_H); go();
    idle(); go();
    wr(44, 32'hFFC, SZ_W, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'hA5A5_5A5A;
    rd(45, 32'hFFC, SZ_W, NONSEQ, 1'b0, 32'hA5A5_5A5A, 1'b0); go();
    err(46, 32'h1000, SZ_W); go();
    err(47, 32'h8, SZ_D); go();
    idle(); go();

    // T5: exclusive pair, repeated exclusive write, reservation killed by normal write
    wr(51, 32'h40, SZ_W, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'h5555_0000;
    rd(52, 32'h40, SZ_W, NONSEQ, 1'b1, 32'h5555_0000, 1'b1); go();
    wr(53, 32'h40, SZ_W, NONSEQ, 1'b1, 1'b1); go(); hwdata = 32'h1234_5678;
    rd(54, 32'h40, SZ_W, NONSEQ, 1'b0, 32'h1234_5678, 1'b0); go();
    wr(55, 32'h40, SZ_W, NONSEQ, 1'b1, 1'b0); go(); hwdata = 32'hCAFE_F00D;
    rd(56, 32'h40, SZ_W, NONSEQ, 1'b0, 32'h1234_5678, 1'b0); go();
    rd(57, 32'h40, SZ_W, NONSEQ, 1'b1, 32'h1234_5678, 1'b1); go();
    wr(58, 32'h40, SZ_W, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'h0F0F_0F0F;
    wr(59, 32'h40, SZ_W, NONSEQ, 1'b1, 1'b0); go(); hwdata = 32'h7777_7777;
    rd(60, 32'h40, SZ_W, NONSEQ, 1'b0, 32'h0F0F_0F0F, 1'b0); go();
    idle(); go();

    // T2: three wait states, INCR4 write and readback
    sel = 1'b1; cur_ws = 3;
    tick();
    c0 = cyc;
    hburst = 3'b011;
    wr(21, 32'h20, SZ_W, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'h0101_0101;
    wr(22, 32'h24, SZ_W, SEQ,    1'b0, 1'b0); go(); hwdata = 32'h0202_0202;
    wr(23, 32'h28, SZ_W, SEQ,    1'b0, 1'b0); go(); hwdata = 32'h0303_0303;
    wr(24, 32'h2C, SZ_W, SEQ,    1'b0, 1'b0); go(); hwdata = 32'h0404_0404;
    idle(); go();
    chk("t2_burst_cycles", 32'(cyc - c0 - 1), 32'd16);
    hburst = 3'b011;
    rd(25, 32'h20, SZ_W, NONSEQ, 1'b0, 32'h0101_0101, 1'b0); go();
    rd(26, 32'h24, SZ_W, SEQ,    1'b0, 32'h0202_0202, 1'b0); go();
    rd(27, 32'h28, SZ_W, SEQ,    1'b0, 32'h0303_0303, 1'b0); go();
    rd(28, 32'h2C, SZ_W, SEQ,    1'b0, 32'h0404_0404, 1'b0); go();
    idle(); go();

    // T6: reset during the second wait cycle of a write drops it
    wr(61, 32'h30, SZ_W, NONSEQ, 1'b0, 1'b0); go(); hwdata = 32'h600D_CAFE;
    idle(); go();
    mon_en = 1'b0;
    drive(32'h30, 1'b1, SZ_W, NONSEQ, 1'b0);
    tick();
    hwdata = 32'h0BAD_F00D;
    idle();
    chk("t6_wait1", 32'(ready), 32'h0);
    tick();
    chk("t6_wait2", 32'(ready), 32'h0);
    hrst = 1'b1;
    tick();
    chk("t6_rst_ready", 32'(ready), 32'h1);
    chk("t6_rst_resp",  32'(resp),  32'h0);
    chk("t6_rst_exok",  32'(exok),  32'h0);
    chk("t6_rst_rdata", rdata,      32'h0);
    hrst = 1'b0;
    tick();
    mon_en = 1'b1;
    rd(62, 32'h30, SZ_W, NONSEQ, 1'b0, 32'h600D_CAFE, 1'b0); go();
    idle(); go();

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
